// File: rtl/serial_frame_pkg.sv
// rtl/serial_frame_pkg.sv - shared types, constants and parity helper for the serial frame receiver
package serial_frame_pkg;

    // Level of the serial line between frames.
    localparam logic SERIAL_IDLE = 1'b1;

    // Widest data word the parity helper accepts. Narrower words are
    // zero-extended by the caller, which leaves the XOR reduction unchanged.
    localparam int MAX_DATA_BITS = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // Returns the bit that makes the word plus parity bit have an even
    // number of ones.
    function automatic logic even_parity(input logic [MAX_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// rtl/bit_timer.sv - free-running bit-period counter with half-bit and full-bit strobes
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset, counter returns to 0
//   restart   counter is forced to 0 on this edge (phase realignment)
//   half_tick high while the counter sits at CLKS_PER_BIT/2-1, i.e. the
//             next edge is HALF edges after the last restart
//   bit_tick  high while the counter sits at CLKS_PER_BIT-1, i.e. the next
//             edge closes a full bit period
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic half_tick,
    output logic bit_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign half_tick = (cnt_q == HALF_M1);
    assign bit_tick  = (cnt_q == LAST);

endmodule

// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - serial frame receiver (start, LSB-first data, even parity, stop) with valid/ready output
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   serial_in  serial line, idle high, already synchronous to clk
//   ready      consumer accepts the held frame when valid && ready
//   data_out   received data word, bit 0 is the first data bit on the line
//   valid      data_out / parity_err / frame_err hold a frame
//   parity_err even-parity mismatch of the held frame
//   frame_err  stop bit of the held frame was sampled low
//   overrun    one-cycle pulse when a completed frame had to be dropped
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic                 ready,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int BCW = $clog2(DATA_BITS + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

    rx_state_t            state_q, state_d;
    logic                 armed_q, armed_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 frame_perr_q, frame_perr_d;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;

    logic restart;
    logic half_tick;
    logic bit_tick;
    logic complete;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .restart  (restart),
        .half_tick(half_tick),
        .bit_tick (bit_tick)
    );

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        frame_perr_d = frame_perr_q;
        restart      = 1'b0;
        complete     = 1'b0;
        // A line held low out of reset must not look like a start bit;
        // the receiver only listens once it has seen the idle level.
        armed_d      = armed_q | (serial_in == SERIAL_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (armed_q && (serial_in != SERIAL_IDLE)) begin
                    state_d = ST_START;
                    restart = 1'b1;
                end
            end
            ST_START: begin
                if (half_tick) begin
                    if (serial_in == SERIAL_IDLE) begin
                        state_d = ST_IDLE;
                    end else begin
                        // Re-phase the timer so every later bit_tick lands
                        // mid-bit, one full period apart.
                        state_d   = ST_DATA;
                        restart   = 1'b1;
                        bit_cnt_d = '0;
                    end
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shift_d                = shift_q >> 1;
                    shift_d[DATA_BITS-1]   = serial_in;
                    bit_cnt_d              = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    frame_perr_d = even_parity(MAX_DATA_BITS'(shift_q)) ^ serial_in;
                    state_d      = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = 1'b0;

        if (complete) begin
            // A frame finishing on the same edge the old one is taken
            // replaces it directly, so valid stays high without a gap.
            if (!valid_q || ready) begin
                data_d  = shift_q;
                perr_d  = frame_perr_q;
                ferr_d  = (serial_in != SERIAL_IDLE);
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            armed_q      <= 1'b0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            frame_perr_q <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            frame_perr_q <= frame_perr_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            ovr_q        <= ovr_d;
        end
    end

    assign data_out   = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - directed self-checking bench for serial_frame_rx
module tb_serial_frame_rx;

    localparam int CPB = 4;
    localparam int DB  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          serial_in = 1'b1;
    logic          ready = 1'b1;
    logic [DB-1:0] data_out;
    logic          valid;
    logic          parity_err;
    logic          frame_err;
    logic          overrun;

    serial_frame_rx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .serial_in (serial_in),
        .ready     (ready),
        .data_out  (data_out),
        .valid     (valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Posedge counter; at a negedge it equals the index of the last edge.
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Output monitor, sampled mid-cycle.
    int            valid_cycles = 0;
    int            rise_cyc     = -1;
    int            ovr_cnt      = 0;
    int            ovr_cyc      = -1;
    logic          vprev        = 1'b0;
    logic [DB-1:0] cap_data     = '0;
    logic          cap_perr     = 1'b0;
    logic          cap_ferr     = 1'b0;

    always @(negedge clk) begin
        if (valid && !vprev) rise_cyc = cyc;
        if (valid) begin
            valid_cycles = valid_cycles + 1;
            cap_data     = data_out;
            cap_perr     = parity_err;
            cap_ferr     = frame_err;
        end
        if (overrun) begin
            ovr_cnt = ovr_cnt + 1;
            ovr_cyc = cyc;
        end
        vprev = valid;
    end

    int start_k = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; drives start, data LSB-first, parity, stop, then
    // returns the line to idle at a negedge.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        logic [10:0] fr;
        fr      = {stp, par, d, 1'b0};
        start_k = cyc + 1;
        for (int i = 0; i < 11; i++) begin
            serial_in = fr[i];
            repeat (CPB) @(negedge clk);
        end
        serial_in = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_data"},  32'(data_out),   32'h0);
        check_eq({tag, "_valid"}, 32'(valid),      32'h0);
        check_eq({tag, "_perr"},  32'(parity_err), 32'h0);
        check_eq({tag, "_ferr"},  32'(frame_err),  32'h0);
        check_eq({tag, "_ovr"},   32'(overrun),    32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int o0;
        int k1;
        logic [7:0] d5a;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Clean frame, ready high: 42-edge latency, one valid cycle.
        ready = 1'b1;
        v0 = valid_cycles; o0 = ovr_cnt;
        send_frame(8'hA5, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check_eq("a5_latency", 32'(rise_cyc - start_k), 32'd42);
        check_eq("a5_data",    32'(cap_data), 32'hA5);
        check_eq("a5_perr",    32'(cap_perr), 32'h0);
        check_eq("a5_ferr",    32'(cap_ferr), 32'h0);
        check_eq("a5_vcycles", 32'(valid_cycles - v0), 32'd1);
        check_eq("a5_ovr",     32'(ovr_cnt - o0), 32'd0);

        // Wrong parity, then correct parity with a low stop bit.
        send_frame(8'h01, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check_eq("p01_data", 32'(cap_data), 32'h01);
        check_eq("p01_perr", 32'(cap_perr), 32'h1);
        check_eq("p01_ferr", 32'(cap_ferr), 32'h0);
        send_frame(8'h01, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check_eq("f01_data", 32'(cap_data), 32'h01);
        check_eq("f01_perr", 32'(cap_perr), 32'h0);
        check_eq("f01_ferr", 32'(cap_ferr), 32'h1);

        // False start: line low for two cycles only.
        v0 = valid_cycles;
        serial_in = 1'b0;
        repeat (2) @(negedge clk);
        serial_in = 1'b1;
        repeat (50) @(negedge clk);
        check_eq("false_start_novalid", 32'(valid_cycles - v0), 32'd0);
        send_frame(8'h3C, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check_eq("3c_data",    32'(cap_data), 32'h3C);
        check_eq("3c_perr",    32'(cap_perr), 32'h0);
        check_eq("3c_vcycles", 32'(valid_cycles - v0), 32'd1);

        // Back-to-back frames with ready low: second one is dropped.
        ready = 1'b0;
        o0 = ovr_cnt;
        k1 = cyc + 1;
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check_eq("ovr_data",  32'(data_out), 32'h11);
        check_eq("ovr_valid", 32'(valid), 32'h1);
        check_eq("ovr_count", 32'(ovr_cnt - o0), 32'd1);
        check_eq("ovr_edge",  32'(ovr_cyc - k1), 32'd86);
        ready = 1'b1;
        @(negedge clk);
        check_eq("ovr_drain", 32'(valid), 32'h0);

        // Same pair, ready raised exactly for the second stop sample.
        ready = 1'b0;
        o0 = ovr_cnt;
        k1 = cyc + 1;
        fork
            begin
                send_frame(8'h11, 1'b0, 1'b1);
                send_frame(8'h22, 1'b0, 1'b1);
            end
            begin
                while (cyc < k1 + 85) @(negedge clk);
                ready = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        check_eq("swap_data",  32'(cap_data), 32'h22);
        check_eq("swap_ovr",   32'(ovr_cnt - o0), 32'd0);
        check_eq("swap_valid", 32'(valid), 32'h0);

        // Reset in the middle of 0x5A's data bits, line held low through it.
        ready = 1'b1;
        d5a = 8'h5A;
        v0 = valid_cycles; o0 = ovr_cnt;
        serial_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            serial_in = d5a[i];
            repeat (CPB) @(negedge clk);
        end
        serial_in = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("midrst");
        repeat (60) @(negedge clk);
        check_eq("midrst_noframe", 32'(valid_cycles - v0), 32'd0);
        serial_in = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(8'h5A, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check_eq("5a_data",    32'(cap_data), 32'h5A);
        check_eq("5a_perr",    32'(cap_perr), 32'h0);
        check_eq("5a_ferr",    32'(cap_ferr), 32'h0);
        check_eq("5a_vcycles", 32'(valid_cycles - v0), 32'd1);
        check_eq("5a_ovr",     32'(ovr_cnt - o0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
